// File: rtl/enigma_rotor_sched.sv
// Sequencing controller for the 3-rotor ENIGMA chain: steps rotors per keypress and returns ciphertext.
// Build option: define ENIGMA_DOUBLE_STEP_EN for the historical middle-rotor double-step.
module enigma_rotor_sched #(
  parameter int unsigned NOTCH0      = 16,
  parameter int unsigned NOTCH1      = 4,
  parameter int unsigned SETTLE_CYC  = 2,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_load,
  input  logic [4:0] cfg_pos0,
  input  logic [4:0] cfg_pos1,
  input  logic [4:0] cfg_pos2,
  input  logic       in_valid,
  input  logic [4:0] in_char,
  output logic       in_ready,
  output logic [4:0] position0,
  output logic [4:0] position1,
  output logic [4:0] position2,
  output logic [4:0] rotor_in,
  input  logic [4:0] rotor_out,
  input  logic       rotor_done,
  output logic       out_valid,
  output logic [4:0] out_char,
  input  logic       out_ready,
  output logic       err
);

  localparam int unsigned CW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [4:0]  LAST = 5'd25;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STEP   = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] OUT    = 2'd3;

  function automatic logic [4:0] inc26(input logic [4:0] x);
    return (x == LAST) ? 5'd0 : x + 5'd1;
  endfunction

  function automatic logic [4:0] clamp26(input logic [4:0] x);
    return (x > LAST) ? 5'd0 : x;
  endfunction

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [4:0]    pos0_nxt, pos1_nxt, pos2_nxt, rotor_in_nxt, out_char_nxt;
  logic          out_valid_nxt, err_nxt;
  logic          step1, step2;

  assign in_ready = (state == IDLE) && !cfg_load;

  // Middle-rotor stepping rule; the slow rotor only ever moves together with the middle one.
`ifdef ENIGMA_DOUBLE_STEP_EN
  assign step1 = (position0 == 5'(NOTCH0)) || (position1 == 5'(NOTCH1));
`else
  assign step1 = (position0 == 5'(NOTCH0));
`endif
  assign step2 = step1 && (position1 == 5'(NOTCH1));

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      position0 <= 5'd0;
      position1 <= 5'd0;
      position2 <= 5'd0;
      rotor_in  <= 5'd0;
      out_char  <= 5'd0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      position0 <= pos0_nxt;
      position1 <= pos1_nxt;
      position2 <= pos2_nxt;
      rotor_in  <= rotor_in_nxt;
      out_char  <= out_char_nxt;
      out_valid <= out_valid_nxt;
      err       <= err_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    pos0_nxt      = position0;
    pos1_nxt      = position1;
    pos2_nxt      = position2;
    rotor_in_nxt  = rotor_in;
    out_char_nxt  = out_char;
    out_valid_nxt = out_valid;
    err_nxt       = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_load) begin
          pos0_nxt = clamp26(cfg_pos0);
          pos1_nxt = clamp26(cfg_pos1);
          pos2_nxt = clamp26(cfg_pos2);
        end else if (in_valid) begin
          if (in_char > LAST) begin
            err_nxt = 1'b1;
          end else begin
            rotor_in_nxt = in_char;
            state_nxt    = STEP;
          end
        end
      end
      STEP: begin
        pos0_nxt  = inc26(position0);
        if (step1) pos1_nxt = inc26(position1);
        if (step2) pos2_nxt = inc26(position2);
        count_nxt = '0;
        state_nxt = SETTLE;
      end
      SETTLE: begin
        // A good sample wins over the timeout when both land on the same cycle.
        if ((count >= CW'(SETTLE_CYC - 1)) && rotor_done) begin
          out_char_nxt  = rotor_out;
          out_valid_nxt = 1'b1;
          state_nxt     = OUT;
        end else if (count >= CW'(TIMEOUT_CYC - 1)) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          count_nxt = count + CW'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_enigma_rotor_sched.sv
// Directed testbench for enigma_rotor_sched with a stub rotor chain driven by the bench.
module tb_enigma_rotor_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_load = 1'b0;
  logic [4:0] cfg_pos0 = 5'd0, cfg_pos1 = 5'd0, cfg_pos2 = 5'd0;
  logic       in_valid = 1'b0;
  logic [4:0] in_char = 5'd0;
  logic       in_ready;
  logic [4:0] position0, position1, position2, rotor_in;
  logic [4:0] rotor_out = 5'd0;
  logic       rotor_done = 1'b1;
  logic       out_valid;
  logic [4:0] out_char;
  logic       out_ready = 1'b1;
  logic       err;

  int tests = 0;
  int fails = 0;

  enigma_rotor_sched dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load),
    .cfg_pos0(cfg_pos0), .cfg_pos1(cfg_pos1), .cfg_pos2(cfg_pos2),
    .in_valid(in_valid), .in_char(in_char), .in_ready(in_ready),
    .position0(position0), .position1(position1), .position2(position2),
    .rotor_in(rotor_in), .rotor_out(rotor_out), .rotor_done(rotor_done),
    .out_valid(out_valid), .out_char(out_char), .out_ready(out_ready), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (time %0t, required < 200000)", $time);
    $fatal(1);
  end

  task automatic load(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    @(negedge clk);
    cfg_load = 1'b1; cfg_pos0 = a; cfg_pos1 = b; cfg_pos2 = c;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  // Presents one key and waits (bounded) until out_valid is seen; lat counts cycles from the handshake.
  task automatic send(input logic [4:0] ch, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_char = ch;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({position0, position1, position2, rotor_in, out_char} !== 25'd0) begin
      fails++; $display("FAIL reset_regs: got %h required 0", {position0, position1, position2, rotor_in, out_char});
    end
    tests++;
    if ({out_valid, err} !== 2'b00) begin
      fails++; $display("FAIL reset_flags: got %b required 00", {out_valid, err});
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_basic;
    int lat;
    load(5'd0, 5'd0, 5'd0);
    rotor_out = 5'd19;
    send(5'd0, lat);
    tests++;
    if (lat !== 4) begin
      fails++; $display("FAIL basic_latency: got %0d required 4", lat);
    end
    tests++;
    if (out_char !== 5'd19) begin
      fails++; $display("FAIL basic_out_char: got %0d required 19", out_char);
    end
    tests++;
    if ({position0, position1, position2} !== {5'd1, 5'd0, 5'd0}) begin
      fails++; $display("FAIL basic_pos: got %0d,%0d,%0d required 1,0,0", position0, position1, position2);
    end
    tests++;
    if (rotor_in !== 5'd0) begin
      fails++; $display("FAIL basic_rotor_in: got %0d required 0", rotor_in);
    end
  endtask

  task automatic test_notch0;
    int lat;
    load(5'd16, 5'd0, 5'd0);
    rotor_out = 5'd7;
    send(5'd5, lat);
    tests++;
    if ({position0, position1, position2} !== {5'd17, 5'd1, 5'd0}) begin
      fails++; $display("FAIL notch0_pos: got %0d,%0d,%0d required 17,1,0", position0, position1, position2);
    end
    tests++;
    if ({rotor_in, out_char} !== {5'd5, 5'd7}) begin
      fails++; $display("FAIL notch0_data: got in=%0d out=%0d required in=5 out=7", rotor_in, out_char);
    end
  endtask

  task automatic test_wrap;
    int lat;
    load(5'd25, 5'd25, 5'd25);
    send(5'd0, lat);
    tests++;
    if ({position0, position1, position2} !== {5'd0, 5'd25, 5'd25}) begin
      fails++; $display("FAIL wrap_pos: got %0d,%0d,%0d required 0,25,25", position0, position1, position2);
    end
  endtask

  task automatic test_double_step;
    int lat;
    logic [14:0] exp2;
`ifdef ENIGMA_DOUBLE_STEP_EN
    exp2 = {5'd18, 5'd5, 5'd1};
`else
    exp2 = {5'd18, 5'd4, 5'd0};
`endif
    load(5'd16, 5'd3, 5'd0);
    send(5'd1, lat);
    tests++;
    if ({position0, position1, position2} !== {5'd17, 5'd4, 5'd0}) begin
      fails++; $display("FAIL double_key1: got %0d,%0d,%0d required 17,4,0", position0, position1, position2);
    end
    send(5'd2, lat);
    tests++;
    if ({position0, position1, position2} !== exp2) begin
      fails++; $display("FAIL double_key2: got %0d,%0d,%0d required %0d,%0d,%0d",
                        position0, position1, position2, exp2[14:10], exp2[9:5], exp2[4:0]);
    end
  endtask

  task automatic test_illegal;
    load(5'd30, 5'd2, 5'd26);
    tests++;
    if ({position0, position1, position2} !== {5'd0, 5'd2, 5'd0}) begin
      fails++; $display("FAIL load_clamp: got %0d,%0d,%0d required 0,2,0", position0, position1, position2);
    end
    @(negedge clk);
    in_valid = 1'b1; in_char = 5'd27;
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if ({err, in_ready} !== 2'b11) begin
      fails++; $display("FAIL illegal_err: got err=%b in_ready=%b required 1 1", err, in_ready);
    end
    @(negedge clk);
    tests++;
    if ({err, out_valid, position0, position1, position2} !== {2'b00, 5'd0, 5'd2, 5'd0}) begin
      fails++; $display("FAIL illegal_nostep: got err=%b ov=%b pos=%0d,%0d,%0d required 0 0 0,2,0",
                        err, out_valid, position0, position1, position2);
    end
  endtask

  task automatic test_timeout;
    int  n;
    bit  seen_ov;
    load(5'd3, 5'd7, 5'd9);
    rotor_done = 1'b0;
    seen_ov = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_char = 5'd1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (err !== 1'b1 && n < 60) begin
      if (out_valid === 1'b1) seen_ov = 1'b1;
      @(negedge clk);
      n++;
    end
    tests++;
    if (n !== 18) begin
      fails++; $display("FAIL timeout_cycle: err seen at cycle %0d required 18", n);
    end
    tests++;
    if ({seen_ov, out_valid, in_ready} !== 3'b001) begin
      fails++; $display("FAIL timeout_state: got seen_ov=%b ov=%b in_ready=%b required 0 0 1", seen_ov, out_valid, in_ready);
    end
    tests++;
    if ({position0, position1, position2} !== {5'd4, 5'd7, 5'd9}) begin
      fails++; $display("FAIL timeout_pos: got %0d,%0d,%0d required 4,7,9", position0, position1, position2);
    end
    rotor_done = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stall;
    int lat;
    out_ready = 1'b0;
    rotor_out = 5'd11;
    send(5'd2, lat);
    tests++;
    if (lat !== 4) begin
      fails++; $display("FAIL stall_latency: got %0d required 4", lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if ({out_valid, out_char, in_ready} !== {1'b1, 5'd11, 1'b0}) begin
        fails++; $display("FAIL stall_hold[%0d]: got ov=%b char=%0d in_ready=%b required 1 11 0", i, out_valid, out_char, in_ready);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++; $display("FAIL stall_release: got ov=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_cfg_priority;
    bit seen_ov;
    seen_ov = 1'b0;
    @(negedge clk);
    cfg_load = 1'b1; cfg_pos0 = 5'd2; cfg_pos1 = 5'd3; cfg_pos2 = 5'd4;
    in_valid = 1'b1; in_char = 5'd6;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL cfg_in_ready: got %b required 0", in_ready);
    end
    @(negedge clk);
    cfg_load = 1'b0; in_valid = 1'b0;
    tests++;
    if ({position0, position1, position2} !== {5'd2, 5'd3, 5'd4}) begin
      fails++; $display("FAIL cfg_load_pos: got %0d,%0d,%0d required 2,3,4", position0, position1, position2);
    end
    repeat (6) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen_ov = 1'b1;
    end
    tests++;
    if ({seen_ov, position0, position1, position2} !== {1'b0, 5'd2, 5'd3, 5'd4}) begin
      fails++; $display("FAIL cfg_no_txn: got ov_seen=%b pos=%0d,%0d,%0d required 0 2,3,4", seen_ov, position0, position1, position2);
    end
  endtask

  task automatic test_rst_mid;
    int lat;
    rotor_out = 5'd9;
    @(negedge clk);
    in_valid = 1'b1; in_char = 5'd4;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if ({position0, position1, position2, rotor_in, out_char, out_valid, err} !== 27'd0) begin
      fails++; $display("FAIL rst_mid_async: got %h required 0",
                        {position0, position1, position2, rotor_in, out_char, out_valid, err});
    end
    @(negedge clk);
    tests++;
    if ({out_valid, err, position0} !== 7'd0) begin
      fails++; $display("FAIL rst_mid_hold: got ov=%b err=%b p0=%0d required 0 0 0", out_valid, err, position0);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL rst_mid_ready: got %b required 1", in_ready);
    end
    send(5'd3, lat);
    tests++;
    if ({position0, position1, position2, out_char} !== {5'd1, 5'd0, 5'd0, 5'd9}) begin
      fails++; $display("FAIL rst_mid_resume: got pos=%0d,%0d,%0d char=%0d required 1,0,0 9",
                        position0, position1, position2, out_char);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_notch0;
    test_wrap;
    test_double_step;
    test_illegal;
    test_timeout;
    test_stall;
    test_cfg_priority;
    test_rst_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
